// File: rtl/alu32_pkg.sv
// Shared definitions for the alu32 execution unit: opcode encodings and the
// signed data word type.
package alu32_pkg;

   localparam int WORD_WIDTH = 32;
   localparam int OP_COUNT   = 16;

   typedef logic signed [WORD_WIDTH-1:0] word_t;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_MOD = 4'd4;
   localparam logic [3:0] OP_AND = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_XOR = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SRA = 4'd9;
   localparam logic [3:0] OP_SRL = 4'd10;
   localparam logic [3:0] OP_SLT = 4'd11;
   localparam logic [3:0] OP_EQ  = 4'd12;
   localparam logic [3:0] OP_MIN = 4'd13;
   localparam logic [3:0] OP_MAX = 4'd14;
   localparam logic [3:0] OP_NOT = 4'd15;

endpackage

// File: rtl/alu32_divmod.sv
// Combinational signed divide/remainder. The quotient truncates toward zero,
// the remainder takes the dividend's sign, and a zero divisor yields zero.
module alu32_divmod
   import alu32_pkg::*;
#(
   parameter int WIDTH = WORD_WIDTH
) (
   input  logic signed [WIDTH-1:0] dividend,
   input  logic signed [WIDTH-1:0] divisor,
   output logic signed [WIDTH-1:0] quotient,
   output logic signed [WIDTH-1:0] remainder
);

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] mag_q;
   logic [WIDTH-1:0] mag_r;

   // Dividing magnitudes as unsigned values makes -2^31 / -1 wrap
   // naturally to -2^31 with a zero remainder, without any special case.
   always_comb begin
      a_neg = dividend[WIDTH-1];
      b_neg = divisor[WIDTH-1];
      mag_a = a_neg ? $unsigned(-dividend) : $unsigned(dividend);
      mag_b = b_neg ? $unsigned(-divisor) : $unsigned(divisor);
      mag_q = '0;
      mag_r = '0;
      if (mag_b != '0) begin
         mag_q = mag_a / mag_b;
         mag_r = mag_a % mag_b;
      end
      quotient  = (a_neg ^ b_neg) ? -$signed(mag_q) : $signed(mag_q);
      remainder = a_neg ? -$signed(mag_r) : $signed(mag_r);
   end

endmodule

// File: rtl/alu32.sv
// 32-bit signed ALU: a combinational opcode mux feeding a single result
// register, so each operation appears on result_y one cycle after it is issued.
module alu32
   import alu32_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int SEL_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [WIDTH-1:0]     data_a,
   input  logic signed [WIDTH-1:0]     data_b,
   input  logic        [SEL_WIDTH-1:0] select,
   output logic signed [WIDTH-1:0]     result_y
);

   localparam int SHW = $clog2(WIDTH);

   logic signed [WIDTH-1:0] quotient;
   logic signed [WIDTH-1:0] remainder;
   logic        [SHW-1:0]   shamt;
   logic                    a_lt_b;
   logic signed [WIDTH-1:0] result_d;
   logic signed [WIDTH-1:0] result_q;

   alu32_divmod #(
      .WIDTH (WIDTH)
   ) u_divmod (
      .dividend  (data_a),
      .divisor   (data_b),
      .quotient  (quotient),
      .remainder (remainder)
   );

   // Any select bit above the 16-entry opcode space forces a zero result.
   always_comb begin
      shamt    = data_b[SHW-1:0];
      a_lt_b   = data_a < data_b;
      result_d = '0;
      if (select[SEL_WIDTH-1:4] == '0) begin
         case (select[3:0])
            OP_ADD:  result_d = data_a + data_b;
            OP_SUB:  result_d = data_a - data_b;
            OP_MUL:  result_d = data_a * data_b;
            OP_DIV:  result_d = quotient;
            OP_MOD:  result_d = remainder;
            OP_AND:  result_d = data_a & data_b;
            OP_OR:   result_d = data_a | data_b;
            OP_XOR:  result_d = data_a ^ data_b;
            OP_SHL:  result_d = data_a << shamt;
            OP_SRA:  result_d = data_a >>> shamt;
            OP_SRL:  result_d = $signed($unsigned(data_a) >> shamt);
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, a_lt_b};
            OP_EQ:   result_d = {{(WIDTH-1){1'b0}}, data_a == data_b};
            OP_MIN:  result_d = a_lt_b ? data_a : data_b;
            OP_MAX:  result_d = a_lt_b ? data_b : data_a;
            OP_NOT:  result_d = ~data_a;
            default: result_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
      end else begin
         result_q <= result_d;
      end
   end

   assign result_y = result_q;

endmodule

// File: tb/tb_alu32.sv
// Scoreboard bench for alu32: the driver queues the expected result for each
// issued operation and an independent monitor checks one result per clock.
module tb_alu32;
   import alu32_pkg::*;

   localparam int WIDTH     = 32;
   localparam int SEL_WIDTH = 32;

   logic                        clk = 1'b0;
   logic                        rst;
   logic signed [WIDTH-1:0]     data_a;
   logic signed [WIDTH-1:0]     data_b;
   logic        [SEL_WIDTH-1:0] select;
   logic signed [WIDTH-1:0]     result_y;

   typedef struct {
      logic [31:0] expected;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   alu32 #(
      .WIDTH     (WIDTH),
      .SEL_WIDTH (SEL_WIDTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .data_a   (data_a),
      .data_b   (data_b),
      .select   (select),
      .result_y (result_y)
   );

   // Reference model built from integer arithmetic on plain ints.
   function automatic logic [31:0] refModel(input logic [31:0] sel,
                                            input logic [31:0] a_u,
                                            input logic [31:0] b_u);
      int a;
      int b;
      int sh;
      a  = int'(a_u);
      b  = int'(b_u);
      sh = int'(b_u % 32);
      if (sel > 32'd15) return 32'd0;
      case (sel[3:0])
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a * b;
         4'd3:  begin
            if (b == 0) return 32'd0;
            if (a_u == 32'h8000_0000 && b == -1) return 32'h8000_0000;
            return a / b;
         end
         4'd4:  begin
            if (b == 0) return 32'd0;
            if (a_u == 32'h8000_0000 && b == -1) return 32'd0;
            return a % b;
         end
         4'd5:  return a_u & b_u;
         4'd6:  return a_u | b_u;
         4'd7:  return a_u ^ b_u;
         4'd8:  return a_u << sh;
         4'd9:  return a >>> sh;
         4'd10: return a_u >> sh;
         4'd11: return (a < b) ? 32'd1 : 32'd0;
         4'd12: return (a == b) ? 32'd1 : 32'd0;
         4'd13: return (a < b) ? a : b;
         4'd14: return (a < b) ? b : a;
         default: return ~a_u;
      endcase
   endfunction

   task automatic driveInputs(input logic r, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] sel);
      @(negedge clk);
      rst    = r;
      data_a = a;
      data_b = b;
      select = sel;
   endtask

   // Randomized/sweep stimulus: expectation comes from the reference model.
   task automatic applyStimulus(input logic r, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] sel,
                                input string tag);
      exp_t e;
      driveInputs(r, a, b, sel);
      e.expected = r ? 32'd0 : refModel(sel, a, b);
      e.tag      = tag;
      exp_q.push_back(e);
   endtask

   // Directed stimulus with a hand-derived expected constant.
   task automatic applyDirected(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] sel, input logic [31:0] expv,
                                input string tag);
      exp_t e;
      driveInputs(1'b0, a, b, sel);
      e.expected = expv;
      e.tag      = tag;
      exp_q.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (result_y !== e.expected) begin
            miscompares++;
            $display("[TB] FAIL %s: result_y=%h expected=%h", e.tag, result_y, e.expected);
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         checkOutput();
      end
   end

   function automatic logic [31:0] pickOperand();
      logic [31:0] specials[6];
      specials[0] = 32'h0000_0000;
      specials[1] = 32'hFFFF_FFFF;
      specials[2] = 32'h8000_0000;
      specials[3] = 32'h7FFF_FFFF;
      specials[4] = 32'h0000_0001;
      specials[5] = 32'h0000_0021;
      if ($urandom_range(3) == 0) return specials[$urandom_range(5)];
      if ($urandom_range(1) == 0) return 32'($signed($urandom_range(200)) - 100);
      return $urandom;
   endfunction

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      rst    = 1'b1;
      data_a = '0;
      data_b = '0;
      select = '0;

      applyStimulus(1'b1, 32'd5, 32'd3, 32'd0, "reset_0");
      applyStimulus(1'b1, 32'd5, 32'd3, 32'd0, "reset_1");
      applyDirected(32'd5, 32'd3, 32'd0, 32'd8, "post_reset_add");

      applyDirected(32'h7FFF_FFFF, 32'd1, 32'd0, 32'h8000_0000, "add_wrap");
      applyDirected(32'h8000_0000, 32'd1, 32'd1, 32'h7FFF_FFFF, "sub_wrap");
      applyDirected(32'h0001_0000, 32'h0001_0000, 32'd2, 32'd0, "mul_wrap");

      applyDirected(-32'sd7, 32'd2, 32'd3, -32'sd3, "div_neg_a");
      applyDirected(-32'sd7, 32'd2, 32'd4, -32'sd1, "mod_neg_a");
      applyDirected(32'd7, -32'sd2, 32'd3, -32'sd3, "div_neg_b");
      applyDirected(32'd7, -32'sd2, 32'd4, 32'd1, "mod_neg_b");
      applyDirected(32'd12345, 32'd0, 32'd3, 32'd0, "div_by_zero");
      applyDirected(32'd12345, 32'd0, 32'd4, 32'd0, "mod_by_zero");
      applyDirected(32'h8000_0000, 32'hFFFF_FFFF, 32'd3, 32'h8000_0000, "div_overflow");
      applyDirected(32'h8000_0000, 32'hFFFF_FFFF, 32'd4, 32'd0, "mod_overflow");

      applyDirected(32'h8000_0001, 32'd33, 32'd8, 32'h0000_0002, "shl_masked");
      applyDirected(32'h8000_0001, 32'd33, 32'd9, 32'hC000_0000, "sra_masked");
      applyDirected(32'h8000_0001, 32'd33, 32'd10, 32'h4000_0000, "srl_masked");

      applyDirected(32'hFFFF_FFFF, 32'd1, 32'd11, 32'd1, "slt");
      applyDirected(32'hFFFF_FFFF, 32'd1, 32'd12, 32'd0, "eq_false");
      applyDirected(32'd77, 32'd77, 32'd12, 32'd1, "eq_true");
      applyDirected(32'hFFFF_FFFF, 32'd1, 32'd13, 32'hFFFF_FFFF, "min");
      applyDirected(32'hFFFF_FFFF, 32'd1, 32'd14, 32'd1, "max");

      applyDirected(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd5, 32'h00F0_00F0, "and");
      applyDirected(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd6, 32'hFFF0_FFF0, "or");
      applyDirected(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd7, 32'hFF00_FF00, "xor");
      applyDirected(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd15, 32'h0F0F_0F0F, "not");

      applyDirected(32'd5, 32'd3, 32'd16, 32'd0, "sel_16");
      applyDirected(32'd5, 32'd3, 32'hFFFF_FFFF, 32'd0, "sel_all_ones");

      for (int p = 0; p < 50; p++) begin
         a = pickOperand();
         b = pickOperand();
         for (int s = 0; s < OP_COUNT; s++) begin
            applyStimulus(1'b0, a, b, 32'(s), "sweep");
         end
         applyStimulus(1'b0, a, b, 32'd16, "sweep_sel16");
         applyStimulus(1'b0, a, b, 32'hFFFF_FFFF, "sweep_selmax");
         applyStimulus(1'b0, a, b, $urandom | 32'h0000_0010, "sweep_selrand");
      end

      applyStimulus(1'b1, 32'h1234_5678, 32'd9, 32'd0, "reset_dominates");
      applyDirected(32'h1234_5678, 32'd9, 32'd7, 32'h1234_5671, "first_after_reset");

      @(negedge clk);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL drain_timeout: pending=%0d required=0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
